// File: rtl/uart_rx_frontend_if.sv
// ---------------------------------------------------------------------------
// uart_rx_frontend_if
// Groups the serial line and the receive-register bus between the UART
// receiver front end and the peripheral block that consumes its bytes.
//   rxd          : serial line, idle high, asynchronous to the clock
//   rx_ack       : one-cycle pop/clear strobe from the peripheral block
//   rx_data      : received byte holding register
//   rx_status    : holding register full
//   rx_overrun   : sticky, a full byte was overwritten
//   rx_frame_err : sticky, a stop bit was sampled low
//   rx_busy      : a frame is in progress
// Modports: master = line/peripheral side, slave = receiver.
// ---------------------------------------------------------------------------
interface uart_rx_frontend_if;
   logic       rxd;
   logic       rx_ack;
   logic [7:0] rx_data;
   logic       rx_status;
   logic       rx_overrun;
   logic       rx_frame_err;
   logic       rx_busy;

   modport master (
      output rxd, rx_ack,
      input  rx_data, rx_status, rx_overrun, rx_frame_err, rx_busy
   );

   modport slave (
      input  rxd, rx_ack,
      output rx_data, rx_status, rx_overrun, rx_frame_err, rx_busy
   );
endinterface

// File: rtl/uart_rx_frontend.sv
// ---------------------------------------------------------------------------
// uart_rx_frontend
// 16x oversampled 8N1 serial receiver with a one-byte holding register.
// The line is double-flop synchronised, a start is only accepted after the
// line has genuinely been seen idle (high), and completed bytes are offered
// to the peripheral block with overrun and framing-error flags.
// Ports:
//   sysclk : single rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : uart_rx_frontend_if.slave (rxd, rx_ack in; rx_* out)
// Parameters: CLK_HZ, BAUD; DIV = CLK_HZ/(BAUD*16) clocks per oversample tick.
// ---------------------------------------------------------------------------
module uart_rx_frontend #(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned BAUD   = 9600
) (
   input  logic              sysclk,
   input  logic              reset,
   uart_rx_frontend_if.slave bus
);
   localparam int unsigned   DIV        = CLK_HZ / (BAUD * 16);
   localparam int unsigned   PW         = (DIV < 2) ? 1 : $clog2(DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   generate
      if (DIV < 2) begin : g_div_check
         $error("uart_rx_frontend: CLK_HZ/(BAUD*16) must be at least 2");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   state_e        state_q, state_d;
   logic [1:0]    sync_q;                 // [0] first flop, [1] gives rxd_s
   logic [1:0]    sync_vld_q;             // marks sync flops holding real samples
   logic          armed_q, armed_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    samp_q, samp_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          stop_bad_q, stop_bad_d;
   logic [7:0]    data_q, data_d;
   logic          status_q, status_d;
   logic          ovr_q, ovr_d;
   logic          ferr_q, ferr_d;
   logic          busy_q, busy_d;

   logic rxd_s;
   logic tick;
   logic load;
   logic ferr_set;

   assign rxd_s = sync_q[1];
   assign tick  = (presc_q == PRESC_LAST);

   // The sync flops reset high, so their reset value must not count as having
   // seen an idle line; only a sample that came through both flops arms us.
   assign armed_d = armed_q | (sync_vld_q[1] & rxd_s);

   // NOTE: every variable driven here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      presc_d    = tick ? '0 : presc_q + PW'(1);
      samp_d     = tick ? samp_q + 4'd1 : samp_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      stop_bad_d = stop_bad_q;
      load       = 1'b0;
      ferr_set   = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Holding the prescaler at 0 here also gives START a clean entry.
            presc_d    = '0;
            stop_bad_d = 1'b0;
            if (armed_q && !rxd_s) state_d = START;
         end
         START: begin
            // 8th tick is the middle of the start bit; high means a glitch.
            if (tick && samp_q == 4'd7) begin
               if (!rxd_s) begin
                  state_d = DATA;
                  bit_d   = 3'd0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (tick && samp_q == 4'd15) begin
               shift_d = {rxd_s, shift_q[7:1]};   // LSB arrives first
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (stop_bad_q) begin
               // A low stop bit may be a break; wait for the line to idle.
               if (rxd_s) state_d = IDLE;
            end else if (tick && samp_q == 4'd15) begin
               if (rxd_s) begin
                  load    = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_set   = 1'b1;
                  stop_bad_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d != state_q) samp_d = 4'd0;
      busy_d = (state_d != IDLE);

      // Holding register: an ack clears everything, then a load in the same
      // cycle re-fills it; overrun only counts when the byte was not popped.
      data_d   = data_q;
      status_d = status_q;
      ovr_d    = ovr_q;
      ferr_d   = ferr_q;
      if (bus.rx_ack) begin
         status_d = 1'b0;
         ovr_d    = 1'b0;
         ferr_d   = 1'b0;
      end
      if (load) begin
         data_d   = shift_q;
         status_d = 1'b1;
         if (status_q && !bus.rx_ack) ovr_d = 1'b1;
      end
      if (ferr_set) ferr_d = 1'b1;
   end

   // NOTE: sequential state is assigned with non-blocking (<=) only, so every
   // register samples its pre-edge inputs regardless of statement order.
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         // NOTE: the synchroniser resets to the idle-line level (1); all other
         // state, including the shift register, resets to zero.
         sync_q     <= 2'b11;
         sync_vld_q <= 2'b00;
         armed_q    <= 1'b0;
         state_q    <= IDLE;
         presc_q    <= '0;
         samp_q     <= 4'd0;
         bit_q      <= 3'd0;
         shift_q    <= 8'h00;
         stop_bad_q <= 1'b0;
         data_q     <= 8'h00;
         status_q   <= 1'b0;
         ovr_q      <= 1'b0;
         ferr_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         sync_q     <= {sync_q[0], bus.rxd};
         sync_vld_q <= {sync_vld_q[0], 1'b1};
         armed_q    <= armed_d;
         state_q    <= state_d;
         presc_q    <= presc_d;
         samp_q     <= samp_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         stop_bad_q <= stop_bad_d;
         data_q     <= data_d;
         status_q   <= status_d;
         ovr_q      <= ovr_d;
         ferr_q     <= ferr_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.rx_data      = data_q;
   assign bus.rx_status    = status_q;
   assign bus.rx_overrun   = ovr_q;
   assign bus.rx_frame_err = ferr_q;
   assign bus.rx_busy      = busy_q;
endmodule

// File: tb/tb_uart_rx_frontend.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frontend
// Bench for uart_rx_frontend at CLK_HZ=6.4 MHz, BAUD=100k (DIV=4, 64 clocks
// per bit). A transaction-level model of the holding register predicts the
// outputs after every frame and ack.
// ---------------------------------------------------------------------------
module tb_uart_rx_frontend;
   logic sysclk = 1'b0;
   logic reset;

   uart_rx_frontend_if bus();

   uart_rx_frontend #(
      .CLK_HZ (6_400_000),
      .BAUD   (100_000)
   ) dut (
      .sysclk (sysclk),
      .reset  (reset),
      .bus    (bus)
   );

   always #5 sysclk = ~sysclk;

   int n_total = 0;
   int n_bad   = 0;

   // Holding-register model.
   logic [7:0] exp_data;
   logic       exp_st, exp_ovr, exp_ferr;

   function automatic void model_reset();
      exp_data = 8'h00; exp_st = 1'b0; exp_ovr = 1'b0; exp_ferr = 1'b0;
   endfunction

   function automatic void model_ack();
      exp_st = 1'b0; exp_ovr = 1'b0; exp_ferr = 1'b0;
   endfunction

   function automatic void model_frame(input logic [7:0] d, input bit good);
      if (good) begin
         if (exp_st) exp_ovr = 1'b1;
         exp_data = d;
         exp_st   = 1'b1;
      end else begin
         exp_ferr = 1'b1;
      end
   endfunction

   // {status, overrun, frame_err, busy, data}; idle receiver expected busy=0.
   function automatic logic [11:0] obs();
      return {bus.rx_status, bus.rx_overrun, bus.rx_frame_err, bus.rx_busy, bus.rx_data};
   endfunction

   function automatic logic [11:0] expv();
      return {exp_st, exp_ovr, exp_ferr, 1'b0, exp_data};
   endfunction

   // Line level seen at offset o clocks after the falling start edge.
   function automatic logic line_level(input logic [7:0] d, input int bc,
                                       input int sc, input logic sl, input int o);
      if (o < bc)          return 1'b0;
      else if (o < 9 * bc) return d[(o - bc) / bc];
      else if (o < 9 * bc + sc) return sl;
      else                 return 1'b1;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   task automatic pulse_ack();
      @(posedge sysclk); #1 bus.rx_ack = 1'b1;
      @(posedge sysclk); #1 bus.rx_ack = 1'b0;
   endtask

   // Sends one frame. Edge 0 is the clock edge just before the line falls.
   // load_edge: first edge after which status rose or data changed (-1: none).
   task automatic drive_frame(input logic [7:0] d, input int bc, input int sc,
                              input logic sl, input int ack_edge,
                              output int load_edge, output bit busy_seen);
      int         total;
      logic       prev_st;
      logic [7:0] prev_d;
      total     = 9 * bc + sc;
      load_edge = -1;
      busy_seen = 1'b0;
      @(posedge sysclk); #1;
      prev_st = bus.rx_status;
      prev_d  = bus.rx_data;
      bus.rxd = 1'b0;
      for (int c = 1; c <= total; c++) begin
         @(posedge sysclk); #1;
         if (load_edge < 0 && ((bus.rx_status && !prev_st) || bus.rx_data !== prev_d))
            load_edge = c;
         if (bus.rx_busy) busy_seen = 1'b1;
         prev_st    = bus.rx_status;
         prev_d     = bus.rx_data;
         bus.rx_ack = (c + 1 == ack_edge);
         bus.rxd    = line_level(d, bc, sc, sl, c);
      end
      bus.rx_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; bus.rxd = 1'b1; bus.rx_ack = 1'b0;
      model_reset();
      repeat (3) @(posedge sysclk);
      #1;
      n_total++;
      if (obs() !== expv())
         $display("FAIL reset_values: got %h want %h", obs(), expv());
      #2 reset = 1'b1;
      idle(8);
   endtask

   task automatic test_single_byte();
      int le; bit bs;
      drive_frame(8'hA5, 64, 64, 1'b1, -1, le, bs);
      model_frame(8'hA5, 1'b1);
      n_total++;
      if (le < 610 || le > 612) begin
         n_bad++; $display("FAIL a5_latency: load edge %0d want 610..612", le);
      end
      n_total++;
      if (bs !== 1'b1) begin
         n_bad++; $display("FAIL a5_busy_seen: got %b want 1", bs);
      end
      n_total++;
      if (obs() !== expv()) begin
         n_bad++; $display("FAIL a5_frame: got %h want %h", obs(), expv());
      end
      pulse_ack(); model_ack();
      n_total++;
      if (obs() !== expv()) begin
         n_bad++; $display("FAIL a5_ack: got %h want %h", obs(), expv());
      end
   endtask

   task automatic test_back_to_back();
      int le; bit bs;
      drive_frame(8'h3C, 64, 64, 1'b1, -1, le, bs);
      model_frame(8'h3C, 1'b1);
      drive_frame(8'hC3, 64, 64, 1'b1, -1, le, bs);
      model_frame(8'hC3, 1'b1);
      idle(2);
      n_total++;
      if (obs() !== expv()) begin
         n_bad++; $display("FAIL b2b_overrun: got %h want %h", obs(), expv());
      end
      pulse_ack(); model_ack();
      n_total++;
      if (obs() !== expv()) begin
         n_bad++; $display("FAIL b2b_ack: got %h want %h", obs(), expv());
      end
   endtask

   task automatic test_frame_error();
      int le; bit bs;
      drive_frame(8'h77, 64, 64, 1'b1, -1, le, bs);
      model_frame(8'h77, 1'b1);
      drive_frame(8'h5A, 64, 128, 1'b0, -1, le, bs);
      model_frame(8'h5A, 1'b0);
      // Line has only just returned high: receiver must still be waiting.
      n_total++;
      if (bus.rx_busy !== 1'b1) begin
         n_bad++; $display("FAIL ferr_wait_busy: got %b want 1", bus.rx_busy);
      end
      idle(6);
      n_total++;
      if (obs() !== expv()) begin
         n_bad++; $display("FAIL ferr_flags: got %h want %h", obs(), expv());
      end
   endtask

   task automatic test_glitch();
      int rise = -1;
      int fall = -1;
      @(posedge sysclk); #1 bus.rxd = 1'b0;
      for (int c = 1; c <= 80; c++) begin
         @(posedge sysclk); #1;
         if (bus.rx_busy && rise < 0) rise = c;
         if (!bus.rx_busy && rise >= 0 && fall < 0) fall = c;
         bus.rxd = (c < 20) ? 1'b0 : 1'b1;
      end
      n_total++;
      if (rise < 0 || fall - rise != 32) begin
         n_bad++; $display("FAIL glitch_busy: rise %0d fall %0d want span 32", rise, fall);
      end
      n_total++;
      if (obs() !== expv()) begin
         n_bad++; $display("FAIL glitch_noload: got %h want %h", obs(), expv());
      end
   endtask

   task automatic test_reset_mid_frame();
      int le; bit bs;
      bit seen = 1'b0;
      @(posedge sysclk); #1 bus.rxd = 1'b0;
      for (int c = 1; c <= 4 * 64 + 96; c++) begin
         @(posedge sysclk); #1;
         bus.rxd = line_level(8'hFF, 64, 64, 1'b1, c);
      end
      #2 reset = 1'b0; bus.rxd = 1'b0;
      model_reset();
      #1;
      n_total++;
      if (obs() !== expv()) begin
         n_bad++; $display("FAIL rst_mid_clear: got %h want %h", obs(), expv());
      end
      idle(3);
      reset = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(posedge sysclk); #1;
         if (bus.rx_busy) seen = 1'b1;
      end
      n_total++;
      if (seen !== 1'b0) begin
         n_bad++; $display("FAIL rst_low_line_start: got busy %b want 0", seen);
      end
      bus.rxd = 1'b1;
      idle(20);
      drive_frame(8'h81, 64, 64, 1'b1, -1, le, bs);
      model_frame(8'h81, 1'b1);
      n_total++;
      if (obs() !== expv()) begin
         n_bad++; $display("FAIL rst_next_byte: got %h want %h", obs(), expv());
      end
      n_total++;
      if (le < 610 || le > 612) begin
         n_bad++; $display("FAIL rst_next_latency: load edge %0d want 610..612", le);
      end
   endtask

   task automatic test_ack_on_load();
      int le; bit bs;
      pulse_ack(); model_ack();
      drive_frame(8'h11, 64, 64, 1'b1, -1, le, bs);
      model_frame(8'h11, 1'b1);
      drive_frame(8'h42, 64, 64, 1'b1, 611, le, bs);
      // Ack and load on the same edge: equivalent to pop, then fresh load.
      model_ack();
      model_frame(8'h42, 1'b1);
      n_total++;
      if (le != 611) begin
         n_bad++; $display("FAIL ackload_edge: load edge %0d want 611", le);
      end
      n_total++;
      if (obs() !== expv()) begin
         n_bad++; $display("FAIL ackload_state: got %h want %h", obs(), expv());
      end
   endtask

   task automatic test_random();
      int le; bit bs;
      for (int i = 0; i < 10; i++) begin
         logic [7:0] d;
         int         bc;
         bit         good;
         d    = 8'($urandom);
         good = ($urandom_range(0, 4) != 0);
         case ($urandom_range(0, 2))
            0:       bc = 62;
            1:       bc = 64;
            default: bc = 66;
         endcase
         if ($urandom_range(0, 1) == 1) begin
            pulse_ack(); model_ack();
         end
         drive_frame(d, bc, good ? 64 : 96, good, -1, le, bs);
         model_frame(d, good);
         idle(10);
         n_total++;
         if (obs() !== expv()) begin
            n_bad++;
            $display("FAIL random_%0d (byte %h bit %0d good %0b): got %h want %h",
                     i, d, bc, good, obs(), expv());
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_frame_error();
      test_glitch();
      test_reset_mid_frame();
      test_ack_on_load();
      test_random();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

Asynchronous serial receiver that turns the board's `rxd` pin into bytes for the peripheral block's UART receive register. It sits directly upstream of the peripheral block, which polls or interrupts on `rx_status` and pops bytes with `rx_ack`. The block provides:
- input synchronisation;
- 16x oversampled 8N1 framing;
- a one-byte holding register with overrun and framing-error flags.

## Interface
Parameters:
- `CLK_HZ`, default 100_000_000, frequency of `sysclk` in Hz.
- `BAUD`, default 9600, line bit rate.
- Derived `DIV` = floor(CLK_HZ/(BAUD*16)), the sysclk cycles per oversample tick. Must be ≥ 2 (elaboration error otherwise). Default DIV = 651.

Ports:
- `sysclk` in 1: the single clock; everything is rising-edge.
- `reset` in 1: asynchronous, active-low.
- `rxd` in 1: serial line, asynchronous to `sysclk`, idle high.
- `rx_ack` in 1: one-cycle pop/clear strobe from the peripheral block.
- `rx_data` out 8: holding register.
- `rx_status` out 1: holding register full.
- `rx_overrun` out 1: sticky; a full byte was overwritten.
- `rx_frame_err` out 1: sticky; stop bit was sampled low.
- `rx_busy` out 1: a frame is in progress (state ≠ IDLE).

## Operation
Input synchronisation:
- `rxd` passes through 2 flops, giving `rxd_s`.
- An `armed` flag sets when `rxd_s`=1 is seen. Starts are accepted only while armed, so a line held low through reset release is ignored.

Oversample timing:
- A prescaler counts 0..DIV-1 and emits `tick` when it equals DIV-1.
- The prescaler is forced to 0 in IDLE and on entry to START.
- A 4-bit sample counter advances on each `tick` and is cleared on every state change.

State machine (IDLE, START, DATA, STOP):
- **IDLE:** when armed and `rxd_s`=0, go to START.
- **START:** on the 8th tick (mid start bit), sample `rxd_s`.
  - 0 → go to DATA with bit index 0.
  - 1 → glitch; return to IDLE with nothing reported.
- **DATA:** every 16th tick, shift `rxd_s` into bit 7 of the shift register (shift right, LSB first) and increment the bit index. After bit 7, go to STOP.
- **STOP:** on the 16th tick, sample `rxd_s`.
  - 1 → good frame: load `rx_data` from the shift register, set `rx_status`, go to IDLE.
  - 0 → framing error: set `rx_frame_err`, discard the byte, leave `rx_data` unchanged. Stay in STOP until `rxd_s`=1, then go to IDLE.

Holding register:
- Load while `rx_status`=1 and `rx_ack`=0: overwrite `rx_data` and set `rx_overrun`.
- `rx_ack`=1: clear `rx_status`, `rx_overrun` and `rx_frame_err`.
- `rx_ack` in the same cycle as a load: the load wins. `rx_data` gets the new byte, `rx_status` stays 1, and overrun is not set. Errors from that frame remain.
- `rx_ack` while empty has no effect beyond clearing flags.

## Timing
- **Reset values:** `rx_data`=0x00, `rx_status`=0, `rx_overrun`=0, `rx_frame_err`=0, `rx_busy`=0; state IDLE; armed=0; sync flops=1.
- **Reset mid-frame:** the frame is dropped, everything returns to reset values, and a start is accepted only after the line is seen high.
- **Start detection:** if `rxd` falls before edge 0, `rxd_s` is low after edge 2, and state=START and `rx_busy`=1 after edge 3.
- **Byte latency:** the stop sample occurs on the clock at edge 3 + 152·DIV. `rx_status`, `rx_data` and the flags update on that same edge, with no extra cycle. For DIV=4 this is edge 611 (±1 for edge alignment).
- **Bit sampling:** data bit k is sampled at (8 + 16·(k+1))·DIV clocks after START entry.
- **Back-to-back frames:** the receiver re-enters IDLE before the next start edge. A stop bit of ≥ 9/16 bit time is sufficient.
- **Baud tolerance:** accumulated baud error up to ±3% over the frame must still sample every bit correctly.
- **Output timing:** all outputs are registered, with no combinational path from `rxd` or `rx_ack` to any output.

## Test plan
Bench parameters: CLK_HZ=6_400_000, BAUD=100_000 (DIV=4, 64 clocks/bit).
- Send 0xA5, 8N1, idle high → `rx_status` rises at edge 611±1 with `rx_data`=0xA5, both flags 0, `rx_busy` 1→0. `rx_ack` → `rx_status`=0.
- 0x3C then 0xC3 back-to-back with no ack → `rx_data`=0xC3, `rx_status`=1, `rx_overrun`=1. `rx_ack` clears both.
- 0x5A with the stop bit driven low for 2 bit times → `rx_frame_err`=1, `rx_data` unchanged, `rx_status` unchanged. IDLE is re-entered only after the line returns high.
- 20-clock low pulse (shorter than half a bit) → no byte loaded, `rx_busy` returns to 0 after 8 ticks (32 clocks).
- `reset` asserted at bit 4 of 0xFF → all outputs 0. With `rxd` held low across release, there is no start until high. A subsequent 0x81 is received correctly.
- `rx_ack` pulsed on the exact load edge of 0x42 while full with 0x11 → `rx_data`=0x42, `rx_status`=1, `rx_overrun`=0.
